pn_stack_eval: RTL and testbench

Parametrised successor to the fixed-size Polish-notation calculator. It buffers one token stream and evaluates it as a prefix or postfix expression, one token per cycle, on an explicit operand stack. It reports a result plus an error code through a valid/ready output handshake. It sits between the token source and the result consumer in the PN datapath.

---
 rtl/pn_pkg.sv | 34 +++
 rtl/pn_stack_eval_alu.sv | 53 +++++
 rtl/pn_stack_eval.sv | 221 ++++++++++++++++++++++
 tb/tb_pn_stack_eval.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// Shared definitions for the Polish-notation stack evaluator:
// opcodes, error codes, FSM states and the buffered token format.
package pn_pkg;

   // Widest token value the buffer can hold; IN_W must not exceed it.
   localparam int unsigned PN_TOKV_W = 8;

   localparam logic [2:0] OP_ADD    = 3'd0;
   localparam logic [2:0] OP_SUB    = 3'd1;
   localparam logic [2:0] OP_MUL    = 3'd2;
   localparam logic [2:0] OP_ABSADD = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;

   localparam logic [2:0] ERR_OK        = 3'd0;
   localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
   localparam logic [2:0] ERR_STKOVF    = 3'd2;
   localparam logic [2:0] ERR_LEFTOVER  = 3'd3;
   localparam logic [2:0] ERR_BADOP     = 3'd4;
   localparam logic [2:0] ERR_TOKOVF    = 3'd5;
   localparam logic [2:0] ERR_DIVZERO   = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EVAL = 2'd2,
      ST_OUT  = 2'd3
   } pn_state_e;

   typedef struct packed {
      logic                 operator;
      logic [PN_TOKV_W-1:0] value;
   } pn_tok_t;

endpackage

// File: rtl/pn_stack_eval_alu.sv
// Combinational operator unit f(a,b,op) for the PN evaluator.
// Macro PN_DIV_EN: when defined, opcode 4 is signed division; otherwise it is reserved.
module pn_alu
   import pn_pkg::*;
#(
   parameter int unsigned DW  = 32,
   parameter int unsigned OPW = 3
) (
   input  logic [DW-1:0]  a,
   input  logic [DW-1:0]  b,
   input  logic [OPW-1:0] op,
   output logic [DW-1:0]  result,
   output logic           bad_op,
   output logic           div_zero
);

   logic signed [DW-1:0] sa;
   logic signed [DW-1:0] sb;
   logic signed [DW-1:0] sum;

   assign sa  = a;
   assign sb  = b;
   assign sum = sa + sb;

`ifdef PN_DIV_EN
   localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
`endif

   always_comb begin
      result   = '0;
      bad_op   = 1'b0;
      div_zero = 1'b0;
      case (op)
         OPW'(OP_ADD):    result = sum;
         OPW'(OP_SUB):    result = sa - sb;
         OPW'(OP_MUL):    result = sa * sb;
         OPW'(OP_ABSADD): result = sum[DW-1] ? -sum : sum;
`ifdef PN_DIV_EN
         OPW'(OP_DIV): begin
            // MOST_NEG / -1 overflows; it is defined to wrap back to MOST_NEG
            if (sb == '0)
               div_zero = 1'b1;
            else if (sa == MOST_NEG && sb == '1)
               result = MOST_NEG;
            else
               result = sa / sb;
         end
`endif
         default:         bad_op = 1'b1;
      endcase
   end

endmodule

// File: rtl/pn_stack_eval.sv
// Buffers one token burst, then evaluates it as prefix or postfix on an operand
// stack, one token per cycle. Optional divide is controlled by macro PN_DIV_EN (see pn_alu).
module pn_stack_eval
   import pn_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned IN_W      = 3,
   parameter int unsigned TOK_DEPTH = 16,
   parameter int unsigned STK_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            mode,
   input  logic            operator,
   input  logic [IN_W-1:0] in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out,
   output logic [2:0]      out_err
);

   localparam int unsigned CW  = $clog2(TOK_DEPTH + 1);
   localparam int unsigned IW  = $clog2(TOK_DEPTH);
   localparam int unsigned SW  = $clog2(STK_DEPTH + 1);
   localparam int unsigned SAW = $clog2(STK_DEPTH);
   localparam logic [CW-1:0] TOK_FULL = CW'(TOK_DEPTH);
   localparam logic [SW-1:0] STK_FULL = SW'(STK_DEPTH);

   pn_state_e      state_q, state_d;
   logic           mode_q, mode_d;
   logic           tokovf_q, tokovf_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  pos_q, pos_d;
   pn_tok_t        cur_q, cur_d;
   logic           cur_vld_q, cur_vld_d;
   logic [SW-1:0]  sp_q, sp_d;
   logic [DW-1:0]  res_q, res_d;
   logic [2:0]     err_q, err_d;
   pn_tok_t        tok_q [TOK_DEPTH];
   pn_tok_t        tok_d [TOK_DEPTH];
   logic [DW-1:0]  stk_q [STK_DEPTH];
   logic [DW-1:0]  stk_d [STK_DEPTH];

   pn_tok_t        tok_in;
   logic [IW-1:0]  fidx;
   logic [SAW-1:0] sp_m1;
   logic [SAW-1:0] sp_m2;
   logic [DW-1:0]  top;
   logic [DW-1:0]  nxt;
   logic [DW-1:0]  alu_a;
   logic [DW-1:0]  alu_b;
   logic [DW-1:0]  alu_res;
   logic           alu_bad;
   logic           alu_dz;
   logic [2:0]     err_v;

   assign tok_in.operator = operator;
   assign tok_in.value    = PN_TOKV_W'(in);

   // Prefix fetches from the end of the buffer, postfix from the start.
   assign fidx  = mode_q ? pos_q[IW-1:0] : IW'(cnt_q - pos_q - CW'(1));
   assign sp_m1 = SAW'(sp_q - SW'(1));
   assign sp_m2 = SAW'(sp_q - SW'(2));
   assign top   = stk_q[sp_m1];
   assign nxt   = stk_q[sp_m2];
   assign alu_a = mode_q ? nxt : top;
   assign alu_b = mode_q ? top : nxt;

   pn_alu #(
      .DW  (DW),
      .OPW (IN_W)
   ) u_alu (
      .a        (alu_a),
      .b        (alu_b),
      .op       (cur_q.value[IN_W-1:0]),
      .result   (alu_res),
      .bad_op   (alu_bad),
      .div_zero (alu_dz)
   );

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      tokovf_d  = tokovf_q;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      cur_d     = cur_q;
      cur_vld_d = cur_vld_q;
      sp_d      = sp_q;
      res_d     = res_q;
      err_d     = err_q;
      tok_d     = tok_q;
      stk_d     = stk_q;
      err_v     = ERR_OK;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               tok_d[0] = tok_in;
               cnt_d    = CW'(1);
               mode_d   = mode;
               tokovf_d = 1'b0;
               state_d  = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (in_valid) begin
               if (cnt_q < TOK_FULL) begin
                  tok_d[cnt_q[IW-1:0]] = tok_in;
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  tokovf_d = 1'b1;
               end
            end else if (tokovf_q) begin
               res_d   = '0;
               err_d   = ERR_TOKOVF;
               state_d = ST_OUT;
            end else begin
               pos_d     = '0;
               cur_vld_d = 1'b0;
               sp_d      = '0;
               state_d   = ST_EVAL;
            end
         end

         ST_EVAL: begin
            // Token buffer read is registered: cur_q is executed while the next token is fetched.
            if (cur_vld_q) begin
               if (!cur_q.operator) begin
                  if (sp_q == STK_FULL) begin
                     err_v = ERR_STKOVF;
                  end else begin
                     stk_d[sp_q[SAW-1:0]] = DW'(cur_q.value);
                     sp_d = sp_q + SW'(1);
                  end
               end else if (sp_q < SW'(2)) begin
                  err_v = ERR_UNDERFLOW;
               end else if (alu_bad) begin
                  err_v = ERR_BADOP;
               end else if (alu_dz) begin
                  err_v = ERR_DIVZERO;
               end else begin
                  stk_d[sp_m2] = alu_res;
                  sp_d = sp_q - SW'(1);
               end
            end

            if (err_v != ERR_OK) begin
               res_d   = '0;
               err_d   = err_v;
               state_d = ST_OUT;
            end else if (pos_q == cnt_q) begin
               if (sp_d == SW'(1)) begin
                  res_d = stk_d[0];
                  err_d = ERR_OK;
               end else begin
                  res_d = '0;
                  err_d = ERR_LEFTOVER;
               end
               state_d = ST_OUT;
            end else begin
               cur_d     = tok_q[fidx];
               cur_vld_d = 1'b1;
               pos_d     = pos_q + CW'(1);
            end
         end

         ST_OUT: begin
            if (out_ready) begin
               cnt_d     = '0;
               pos_d     = '0;
               cur_vld_d = 1'b0;
               sp_d      = '0;
               tokovf_d  = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= 1'b0;
         tokovf_q  <= 1'b0;
         cnt_q     <= '0;
         pos_q     <= '0;
         cur_q     <= '0;
         cur_vld_q <= 1'b0;
         sp_q      <= '0;
         res_q     <= '0;
         err_q     <= '0;
         for (int unsigned i = 0; i < TOK_DEPTH; i++) tok_q[i] <= '0;
         for (int unsigned i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         tokovf_q  <= tokovf_d;
         cnt_q     <= cnt_d;
         pos_q     <= pos_d;
         cur_q     <= cur_d;
         cur_vld_q <= cur_vld_d;
         sp_q      <= sp_d;
         res_q     <= res_d;
         err_q     <= err_d;
         tok_q     <= tok_d;
         stk_q     <= stk_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_OUT);
   assign out       = out_valid ? res_q : '0;
   assign out_err   = out_valid ? err_q : '0;

endmodule

// File: tb/tb_pn_stack_eval.sv
// Scoreboard bench for pn_stack_eval: directed expressions, latency, hold, reset and error codes.
module tb_pn_stack_eval;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mode = 1'b0;
   logic        operator = 1'b0;
   logic [2:0]  in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out;
   logic [2:0]  out_err;

   always #5 clk = ~clk;

   pn_stack_eval #(
      .DW        (32),
      .IN_W      (3),
      .TOK_DEPTH (16),
      .STK_DEPTH (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .operator  (operator),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_err   (out_err)
   );

`ifdef PN_DIV_EN
   localparam logic [2:0]  DIV0_ERR = 3'd6;
   localparam logic [31:0] DIV_RES  = 32'd3;
   localparam logic [2:0]  DIV_ERR  = 3'd0;
`else
   localparam logic [2:0]  DIV0_ERR = 3'd4;
   localparam logic [31:0] DIV_RES  = 32'd0;
   localparam logic [2:0]  DIV_ERR  = 3'd4;
`endif

   typedef struct {
      int          id;
      logic [31:0] res;
      logic [2:0]  err;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] seq[$];   // {is_operator, value}
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted result is popped and compared.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got %0h/%0d, expected no result", out, out_err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("t%0d out", e.id), out, e.res);
            chk($sformatf("t%0d out_err", e.id), {29'd0, out_err}, {29'd0, e.err});
         end
      end
   end

   // mode is toggled after the first beat to show it is only sampled there.
   task automatic drive_beats(input logic m);
      foreach (seq[i]) begin
         in_valid = 1'b1;
         mode     = (i == 0) ? m : ~m;
         operator = seq[i][3];
         in       = seq[i][2:0];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send(input int id, input logic m, input logic [31:0] er,
                       input logic [2:0] ee, input int lat, input int hold);
      exp_t e;
      int   cyc;
      e.id = id; e.res = er; e.err = ee;
      sb.push_back(e);
      if (hold > 0) out_ready = 1'b0;
      drive_beats(m);
      cyc = 0;
      while (!out_valid && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!out_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL t%0d timeout: got no out_valid, expected it within 60 cycles", id);
      end else if (lat > 0) begin
         chk($sformatf("t%0d latency", id), cyc, lat);
      end
      if (hold > 0) begin
         repeat (hold) begin
            in_valid = 1'b1; operator = 1'b0; in = 3'd5;
            @(posedge clk); #1;
            chk($sformatf("t%0d hold out_valid", id), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t%0d hold out", id), out, er);
            chk($sformatf("t%0d hold in_ready", id), {31'd0, in_ready}, 32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      cyc = 0;
      while (out_valid && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (out_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL t%0d release: got out_valid=1, expected 0 after handshake", id);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out", out, 32'd0);
      chk("reset out_err", {29'd0, out_err}, 32'd0);
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      seq = '{4'h9, 4'h8, 4'h3, 4'h4, 4'h2};          // prefix - + 3 4 2
      send(1, 1'b0, 32'd5, 3'd0, 6, 0);
      seq = '{4'h1, 4'h6, 4'h9, 4'h2, 4'hB};          // postfix 1 6 - 2 |+|
      send(2, 1'b1, 32'd3, 3'd0, 6, 0);
      seq = '{4'h3, 4'h8};                            // underflow
      send(3, 1'b1, 32'd0, 3'd1, 3, 0);
      seq.delete();
      repeat (9) seq.push_back(4'h1);                 // 9th push overflows
      send(4, 1'b1, 32'd0, 3'd2, 10, 0);
      seq.delete();
      repeat (17) seq.push_back(4'h2);                // token overflow
      send(5, 1'b1, 32'd0, 3'd5, 0, 0);
      seq = '{4'h3, 4'h4};                            // leftover
      send(6, 1'b1, 32'd0, 3'd3, 3, 0);
      seq = '{4'h7, 4'h7, 4'hA, 4'h7, 4'hA};          // 7*7*7 with consumer stall
      send(7, 1'b1, 32'd343, 3'd0, 6, 3);
      seq = '{4'h5, 4'h2, 4'h9};                      // postfix 5-2
      send(8, 1'b1, 32'd3, 3'd0, 4, 0);
      seq = '{4'h9, 4'h2, 4'h5};                      // prefix 2-5
      send(9, 1'b0, 32'hFFFF_FFFD, 3'd0, 4, 0);
      seq = '{4'hB, 4'h1, 4'h9, 4'h2, 4'h7};          // prefix |1 + (2-7)|
      send(10, 1'b0, 32'd4, 3'd0, 6, 0);

      seq = '{4'h1, 4'h2, 4'h8, 4'h3, 4'h8};          // aborted by reset mid-EVAL
      drive_beats(1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
      chk("midreset out", out, 32'd0);
      chk("midreset out_err", {29'd0, out_err}, 32'd0);
      chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      seq = '{4'h2, 4'h3, 4'hA};                      // postfix 2*3
      send(11, 1'b1, 32'd6, 3'd0, 4, 0);
      seq = '{4'h6, 4'h0, 4'hC};                      // divide by zero
      send(12, 1'b1, 32'd0, DIV0_ERR, 4, 0);
      seq = '{4'h7, 4'h2, 4'hC};                      // 7/2
      send(13, 1'b1, DIV_RES, DIV_ERR, 4, 0);
      seq = '{4'h1, 4'h2, 4'hD};                      // reserved opcode 5
      send(14, 1'b1, 32'd0, 3'd4, 4, 0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk("scoreboard drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
